mem_port_arbiter: RTL and testbench

- Shares the single instruction/data memory port between two requesters.
  - Port 0: the instruction fetch unit.
  - Port 1: the load/store path.
- Each requester sees the same interface fetch already uses: hold addr_valid/addr until a one-cycle mem_valid pulse returns data.
- The arbiter grants one requester at a time, round-robin, and locks the grant until that transaction completes.
- A watchdog terminates transactions whose response never arrives.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and load/store (port 1), with a per-transaction watchdog.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int ADDR_W  = `ADDRESS_WIDTH,
  parameter int DATA_W  = `DATA_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req0_addr_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  output logic              o_req0_mem_valid,
  output logic [DATA_W-1:0] o_req0_mem_data,
  input  logic              i_req1_addr_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic              i_req1_we,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_req1_mem_valid,
  output logic [DATA_W-1:0] o_req1_mem_data,
  output logic              o_mem_addr_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [1:0]        o_grant,
  output logic              o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RECOVER} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;   // 1 = port 1 held the most recent grant
  logic [7:0]  wdog_q, wdog_d;
  logic        sel_valid;

  assign sel_valid = grant_q[1] ? i_req1_addr_valid : i_req0_addr_valid;
  assign o_grant   = grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_d           = last_q;
    wdog_d           = wdog_q;
    o_mem_addr_valid = 1'b0;
    o_mem_addr       = '0;
    o_mem_we         = 1'b0;
    o_mem_wdata      = '0;
    o_req0_mem_valid = 1'b0;
    o_req0_mem_data  = '0;
    o_req1_mem_valid = 1'b0;
    o_req1_mem_data  = '0;
    o_timeout        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req0_addr_valid || i_req1_addr_valid) begin
          state_d = S_BUSY;
          wdog_d  = 8'd0;
          if (i_req0_addr_valid && i_req1_addr_valid)
            grant_d = last_q ? 2'b01 : 2'b10;
          else
            grant_d = i_req0_addr_valid ? 2'b01 : 2'b10;
        end
      end

      S_BUSY: begin
        // The memory request follows the granted requester's live valid, so an
        // abort removes it in the same cycle.
        o_mem_addr_valid = sel_valid;
        if (sel_valid) begin
          o_mem_addr = grant_q[1] ? i_req1_addr : i_req0_addr;
          if (grant_q[1]) begin
            o_mem_we    = i_req1_we;
            o_mem_wdata = i_req1_wdata;
          end
        end
        if (i_mem_valid) begin
          o_req0_mem_valid = grant_q[0];
          o_req0_mem_data  = grant_q[0] ? i_mem_data : '0;
          o_req1_mem_valid = grant_q[1];
          o_req1_mem_data  = grant_q[1] ? i_mem_data : '0;
        end

        // A response takes priority over both abort and watchdog expiry.
        if (i_mem_valid) begin
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = S_IDLE;
        end else if (!sel_valid) begin
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = S_RECOVER;
        end else if (wdog_q == WDOG_LAST) begin
          o_timeout = 1'b1;
          last_d    = grant_q[1];
          grant_d   = 2'b00;
          state_d   = S_RECOVER;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end

      S_RECOVER: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle compared against a
// transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic          req0_v, req1_v, we1, mv;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] wd1, md;
  logic          r0v, r1v, mav, mwe, tmo;
  logic [DW-1:0] r0d, r1d, mwd;
  logic [AW-1:0] maddr;
  logic [1:0]    gnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which port owns the memory, how long it has waited.
  int m_phase;   // 0 idle, 1 busy, 2 recover
  bit m_owner;
  bit m_last;
  int m_silent;
  bit prev_r0v, prev_r1v;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req0_addr_valid(req0_v), .i_req0_addr(a0),
    .o_req0_mem_valid(r0v), .o_req0_mem_data(r0d),
    .i_req1_addr_valid(req1_v), .i_req1_addr(a1),
    .i_req1_we(we1), .i_req1_wdata(wd1),
    .o_req1_mem_valid(r1v), .o_req1_mem_data(r1d),
    .o_mem_addr_valid(mav), .o_mem_addr(maddr),
    .o_mem_we(mwe), .o_mem_wdata(mwd),
    .i_mem_valid(mv), .i_mem_data(md),
    .o_grant(gnt), .o_timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs with the model for the current inputs, then advance one clock.
  task automatic tick();
    bit ownv, busy, e_av, e_r0v, e_r1v, e_to;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [1:0] e_gnt;
    #1;
    busy   = (m_phase == 1);
    ownv   = m_owner ? req1_v : req0_v;
    e_av   = busy && ownv;
    e_addr = e_av ? (m_owner ? a1 : a0) : '0;
    e_wd   = (e_av && m_owner) ? wd1 : '0;
    e_r0v  = busy && !m_owner && mv;
    e_r1v  = busy && m_owner && mv;
    e_gnt  = !busy ? 2'b00 : (m_owner ? 2'b10 : 2'b01);
    e_to   = busy && !mv && ownv && (m_silent + 1 == TO);
    check("mem_addr_valid", 64'(mav), 64'(e_av));
    check("mem_addr", 64'(maddr), 64'(e_addr));
    check("mem_we", 64'(mwe), 64'(e_av && m_owner && we1));
    check("mem_wdata", 64'(mwd), 64'(e_wd));
    check("req0_valid", 64'(r0v), 64'(e_r0v));
    check("req0_data", 64'(r0d), e_r0v ? 64'(md) : 64'd0);
    check("req1_valid", 64'(r1v), 64'(e_r1v));
    check("req1_data", 64'(r1d), e_r1v ? 64'(md) : 64'd0);
    check("grant", 64'(gnt), 64'(e_gnt));
    check("timeout", 64'(tmo), 64'(e_to));
    prev_r0v = e_r0v;
    prev_r1v = e_r1v;
    if (reset) begin
      m_phase = 0; m_last = 1'b1; m_silent = 0;
    end else if (m_phase == 0) begin
      if (req0_v || req1_v) begin
        m_owner  = (req0_v && req1_v) ? !m_last : !req0_v;
        m_phase  = 1;
        m_silent = 0;
      end
    end else if (m_phase == 1) begin
      if (mv) begin
        m_last = m_owner; m_phase = 0;
      end else if (!ownv || e_to) begin
        m_last = m_owner; m_phase = 2;
      end else begin
        m_silent++;
      end
    end else begin
      m_phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req0_v = 0; req1_v = 0; we1 = 0; mv = 0;
    a0 = '0; a1 = '0; wd1 = '0; md = '0;
    m_phase = 0; m_owner = 0; m_last = 1; m_silent = 0;
    prev_r0v = 0; prev_r1v = 0;
    @(posedge clk); #1;
    tick();
    reset = 1'b0;

    // Fetch-only read with a 3-cycle memory latency
    req0_v = 1; a0 = 32'h4;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1; check("d_fetch_grant", 64'(gnt), 64'(2'b01));
      check("d_fetch_addr", 64'(maddr), 64'h4);
      tick();
    end
    mv = 1; md = 32'hDEADBEEF;
    #1; check("d_fetch_r0v", 64'(r0v), 64'd1);
    check("d_fetch_r0d", 64'(r0d), 64'hDEADBEEF);
    check("d_fetch_r1v", 64'(r1v), 64'd0);
    tick();
    req0_v = 0; mv = 0;
    #1; check("d_fetch_idle", 64'(gnt), 64'd0);
    tick();

    // Tie after reset: grants alternate starting with port 0
    reset = 1; tick(); reset = 0;
    req0_v = 1; a0 = 32'h10; req1_v = 1; a1 = 32'h20; we1 = 0;
    for (int i = 0; i < 4; i++) begin
      mv = 0; tick();
      #1; check("d_tie_grant", 64'(gnt), (i % 2) ? 64'(2'b10) : 64'(2'b01));
      mv = 1; md = $urandom; tick();
    end
    req0_v = 0; req1_v = 0; mv = 0; tick();

    // Write from port 1
    req1_v = 1; we1 = 1; a1 = 32'h40; wd1 = 32'h12345678;
    tick();
    #1; check("d_wr_we", 64'(mwe), 64'd1);
    check("d_wr_wdata", 64'(mwd), 64'h12345678);
    mv = 1; md = 32'h0;
    #1; check("d_wr_ack", 64'(r1v), 64'd1);
    check("d_wr_r0v", 64'(r0v), 64'd0);
    tick();
    req1_v = 0; we1 = 0; mv = 0; tick();

    // Watchdog: memory silent for TIMEOUT busy cycles
    req0_v = 1; a0 = 32'h80;
    tick();
    for (int k = 1; k <= TO; k++) begin
      #1; check("d_to_pulse", 64'(tmo), 64'(k == TO));
      tick();
    end
    #1; check("d_to_grant", 64'(gnt), 64'd0);
    mv = 1; md = 32'hBAD0BAD0;
    #1; check("d_to_late", 64'(r0v), 64'd0);
    tick();
    mv = 0; tick();
    #1; check("d_to_regrant", 64'(gnt), 64'(2'b01));
    mv = 1; tick();
    req0_v = 0; mv = 0; tick();

    // Abort of port 1 with port 0 pending
    req0_v = 1; a0 = 32'h100; req1_v = 1; a1 = 32'h44; we1 = 0;
    tick();
    #1; check("d_ab_grant", 64'(gnt), 64'(2'b10));
    tick(); tick();
    req1_v = 0;
    #1; check("d_ab_drop", 64'(mav), 64'd0);
    tick();
    mv = 1; md = 32'h5A5A5A5A;
    #1; check("d_ab_discard", 64'(r1v | r0v), 64'd0);
    tick();
    mv = 0; tick();
    #1; check("d_ab_pending", 64'(gnt), 64'(2'b01));
    mv = 1; tick();
    req0_v = 0; mv = 0; tick();

    // Reset while busy on port 0
    req0_v = 1; a0 = 32'h8; tick();
    reset = 1; tick(); reset = 0;
    #1; check("d_rst_grant", 64'(gnt), 64'd0);
    check("d_rst_mav", 64'(mav), 64'd0);
    req1_v = 1; a1 = 32'hC; tick();
    #1; check("d_rst_tie", 64'(gnt), 64'(2'b01));
    mv = 1; tick();
    req0_v = 0; req1_v = 0; mv = 0; tick();

    // Randomized traffic with aborts, spurious responses and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (prev_r0v) req0_v = 0;
      else if (req0_v) begin if ($urandom_range(19) == 0) req0_v = 0; end
      else if ($urandom_range(2) == 0) begin req0_v = 1; a0 = $urandom; end
      if (prev_r1v) req1_v = 0;
      else if (req1_v) begin if ($urandom_range(19) == 0) req1_v = 0; end
      else if ($urandom_range(2) == 0) begin
        req1_v = 1; a1 = $urandom; we1 = 1'($urandom); wd1 = $urandom;
      end
      mv = ($urandom_range(3) == 0);
      md = $urandom;
      reset = ($urandom_range(149) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
